// File: rtl/seq_divider_16bit_pkg.sv
// Shared definitions for the sequential divider.
//   - div_state_t : FSM state encoding (IDLE/RUN/DONE)
//   - DIV_WIDTH   : default operand/result width
//   - cla4()      : 4-bit carry-lookahead adder group, returns {carry_out, sum}
package seq_divider_16bit_pkg;

    localparam int unsigned DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } div_state_t;

    function automatic logic [4:0] cla4(input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic       cin);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = a ^ b;
        g    = a & b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

endpackage

// File: rtl/seq_divider_16bit_cla_sub.sv
// N-bit subtractor built from cascaded 4-bit CLA groups (ripple between groups).
// Computes diff = a - b as a + ~b + 1; borrow is the inverted carry out.
// Ports:
//   a, b    in  N  minuend / subtrahend
//   diff    out N  a - b (modulo 2^N)
//   borrow  out 1  high when b > a
module cla_sub_nbit
    import seq_divider_16bit_pkg::*;
#(
    parameter int unsigned N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    localparam int unsigned G  = (N + 3) / 4;
    localparam int unsigned NP = G * 4;

    logic [N-1:0]  b_inv;
    logic [NP-1:0] a_p;
    logic [NP-1:0] bn_p;
    logic [NP-1:0] sum_p;
    logic [G:0]    c;
    logic [NP:0]   csum;

    // Top group is zero-padded on both operands, so the real carry out of bit
    // N-1 lands on sum bit N (or on the final group carry when N fills the groups).
    assign b_inv = ~b;
    assign a_p   = NP'(a);
    assign bn_p  = NP'(b_inv);
    assign c[0]  = 1'b1;

    for (genvar gi = 0; gi < G; gi++) begin : g_cla
        assign {c[gi+1], sum_p[4*gi +: 4]} = cla4(a_p[4*gi +: 4], bn_p[4*gi +: 4], c[gi]);
    end

    assign csum   = {c[G], sum_p};
    assign diff   = csum[N-1:0];
    assign borrow = ~csum[N];

    if (NP > N) begin : g_pad
        logic pad_unused;
        assign pad_unused = &{1'b0, csum[NP:N+1]};
    end

endmodule

// File: rtl/seq_divider_16bit.sv
// Multi-cycle unsigned restoring divider, one trial subtraction per clock.
// Ports:
//   clk, rst      clock / synchronous active-high reset
//   start         request, sampled only in IDLE with dividend/divisor
//   quotient      result, held until the next completion
//   remainder     result, held until the next completion
//   busy          high in RUN and DONE
//   done          one-cycle pulse, results valid while high
//   div_by_zero   valid with done, high when divisor was 0
module seq_divider_16bit
    import seq_divider_16bit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);

    div_state_t       state_q;
    logic [WIDTH-1:0] d_q, q_q, r_q;
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q, dbz_q;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] q_d, r_d;
    logic             diff_unused;

    // Shifted remainder is WIDTH+1 bits so MSB-set divisors never overflow.
    assign r_shift = {r_q, q_q[WIDTH-1]};

    cla_sub_nbit #(.N(WIDTH + 1)) u_sub (
        .a      (r_shift),
        .b      ({1'b0, d_q}),
        .diff   (diff),
        .borrow (borrow)
    );

    // A successful trial always leaves a remainder below the divisor, so the top
    // difference bit is zero whenever it is used.
    assign diff_unused = diff[WIDTH];
    assign r_d = borrow ? r_shift[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_d = {q_q[WIDTH-2:0], ~borrow};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            d_q         <= '0;
            q_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
                        if (divisor == '0) begin
                            state_q     <= S_DONE;
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                            done_q      <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            d_q     <= divisor;
                            q_q     <= dividend;
                            r_q     <= '0;
                            cnt_q   <= '0;
                        end
                    end
                end
                S_RUN: begin
                    q_q   <= q_d;
                    r_q   <= r_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q     <= S_DONE;
                        quotient_q  <= q_d;
                        remainder_q <= r_d;
                        dbz_q       <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_16bit.sv
module tb_seq_divider_16bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend, divisor;
    logic [15:0] quotient, remainder;
    logic        busy, done, div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    seq_divider_16bit #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Waits (bounded) for done; lat counts edges after the start edge.
    task automatic wait_done(input int lat0, output int lat, output int bcnt);
        lat  = lat0;
        bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (busy) bcnt++;
    endtask

    task automatic run_div(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] eq, input logic [15:0] er, input logic ez);
        int lat, bc;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = ~a;      // operand changes while busy must not matter
        divisor  = ~b;
        wait_done(0, lat, bc);
        check({name, " latency"}, lat, ez ? 0 : 16);
        check({name, " busy_cycles"}, bc, ez ? 1 : 17);
        check({name, " quotient"}, quotient, eq);
        check({name, " remainder"}, remainder, er);
        check({name, " div_by_zero"}, div_by_zero, ez);
        @(posedge clk); #1;
        check({name, " done_drop"}, done, 0);
        check({name, " busy_drop"}, busy, 0);
    endtask

    initial begin
        int lat, bc, ndone;
        logic [15:0] ra, rb;

        vecs[0]  = '{16'd100,    16'd7,      16'd14,     16'd2,      1'b0};
        vecs[1]  = '{16'hFFFF,   16'd1,      16'hFFFF,   16'd0,      1'b0};
        vecs[2]  = '{16'h8000,   16'hFFFF,   16'd0,      16'h8000,   1'b0};
        vecs[3]  = '{16'd5,      16'd0,      16'hFFFF,   16'd5,      1'b1};
        vecs[4]  = '{16'd9,      16'd3,      16'd3,      16'd0,      1'b0};
        vecs[5]  = '{16'd3,      16'd10,     16'd0,      16'd3,      1'b0};
        vecs[6]  = '{16'd0,      16'h1234,   16'd0,      16'd0,      1'b0};
        vecs[7]  = '{16'hFFFF,   16'hFFFF,   16'd1,      16'd0,      1'b0};
        vecs[8]  = '{16'd1000,   16'd9,      16'd111,    16'd1,      1'b0};
        vecs[9]  = '{16'd200,    16'd13,     16'd15,     16'd5,      1'b0};
        vecs[10] = '{16'd0,      16'd0,      16'hFFFF,   16'd0,      1'b1};
        vecs[11] = '{16'hFFFF,   16'h8000,   16'd1,      16'h7FFF,   1'b0};

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset div_by_zero", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++)
            run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z);

        // start pulse in the middle of RUN is ignored
        @(negedge clk);
        dividend = 16'd1000; divisor = 16'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        dividend = 16'd50; divisor = 16'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(5, lat, bc);
        check("ignored_start latency", lat, 16);
        check("ignored_start quotient", quotient, 111);
        check("ignored_start remainder", remainder, 1);
        @(posedge clk); #1;
        check("ignored_start done_drop", done, 0);
        // back-to-back start in first IDLE cycle
        run_div("back_to_back", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0);

        // reset in the middle of RUN aborts
        @(negedge clk);
        dividend = 16'd1000; divisor = 16'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort quotient", quotient, 0);
        check("abort remainder", remainder, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort div_by_zero", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check("abort no_activity", ndone, 0);
        run_div("after_abort", 16'd200, 16'd13, 16'd15, 16'd5, 1'b0);

        // random operands against a behavioural model
        for (int i = 0; i < 2000; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 16'($urandom_range(0, 15));
                1:       rb = 16'($urandom_range(16'h8000, 16'hFFFF));
                default: rb = 16'($urandom);
            endcase
            if (rb == 16'd0)
                run_div("rand", ra, rb, 16'hFFFF, ra, 1'b1);
            else
                run_div("rand", ra, rb, ra / rb, ra % rb, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
